// File: rtl/cf_fft_pkg.sv
// Shared definitions for the 1024-point FFT control slice: phase codes,
// default transform size and a bit-reverse helper.
package cf_fft_pkg;

  localparam int unsigned FFT_LOG2N = 10;
  localparam int unsigned FFT_N     = 1 << FFT_LOG2N;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'b000,
    PH_LOAD    = 3'b001,
    PH_DRAIN   = 3'b010,
    PH_COMPUTE = 3'b011,
    PH_DONE    = 3'b100,
    PH_UNLOAD  = 3'b110
  } phase_e;

  // Reverses the low w bits of x; w is expected to be an elaboration constant <= 16.
  function automatic logic [15:0] bit_reverse(input logic [15:0] x, input int unsigned w);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < w) r[4'(i)] = x[4'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/cf_fft_bitrev.sv
// Combinational bit-reverser producing the UNLOAD sample address.
module cf_fft_bitrev
  import cf_fft_pkg::*;
#(
  parameter int unsigned W = FFT_LOG2N
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = W'(bit_reverse(16'(a), W));

endmodule

// File: rtl/cf_fft_1024_8_seq.sv
// Control sequencer for the FFT core: load, per-stage compute with drain gaps,
// bit-reversed unload, and a one-cycle done pulse.
module cf_fft_1024_8_seq
  import cf_fft_pkg::*;
#(
  parameter int unsigned LOG2N    = FFT_LOG2N,
  parameter int unsigned BFLY_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [2:0]       phase,
  output logic [LOG2N-1:0] addr,
  output logic [LOG2N-2:0] bfly_idx,
  output logic [3:0]       stage,
  output logic             bfly_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned IW = LOG2N - 1;
  localparam int unsigned DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
  localparam logic [IW-1:0]    BFLY_LAST  = IW'(N / 2 - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(BFLY_LAT - 1);
  localparam logic [3:0]       STAGE_LAST = 4'(LOG2N - 1);

  phase_e           ph;
  logic [LOG2N-1:0] cnt;
  logic [LOG2N-1:0] cnt_rev;
  logic [DW-1:0]    drain;

  // Phase register and all counters; terminal tests are exact equality.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph       <= PH_IDLE;
      cnt      <= '0;
      bfly_idx <= '0;
      stage    <= '0;
      drain    <= '0;
    end else begin
      unique case (ph)
        PH_IDLE: begin
          if (start) ph <= PH_LOAD;
        end
        PH_LOAD: begin
          if (in_valid) begin
            cnt <= cnt + LOG2N'(1);
            if (cnt == CNT_LAST) begin
              ph       <= PH_COMPUTE;
              cnt      <= '0;
              bfly_idx <= '0;
              stage    <= '0;
            end
          end
        end
        PH_COMPUTE: begin
          bfly_idx <= bfly_idx + IW'(1);
          if (bfly_idx == BFLY_LAST) begin
            ph    <= PH_DRAIN;
            drain <= '0;
          end
        end
        PH_DRAIN: begin
          if (drain == DRAIN_LAST) begin
            if (stage == STAGE_LAST) begin
              ph  <= PH_UNLOAD;
              cnt <= '0;
            end else begin
              ph       <= PH_COMPUTE;
              stage    <= stage + 4'(1);
              bfly_idx <= '0;
            end
          end else begin
            drain <= drain + DW'(1);
          end
        end
        PH_UNLOAD: begin
          if (out_ready) begin
            cnt <= cnt + LOG2N'(1);
            if (cnt == CNT_LAST) begin
              ph  <= PH_DONE;
              cnt <= '0;
            end
          end
        end
        PH_DONE: begin
          ph       <= PH_IDLE;
          stage    <= '0;
          bfly_idx <= '0;
        end
        default: ph <= PH_IDLE;
      endcase
    end
  end

  cf_fft_bitrev #(.W(LOG2N)) u_bitrev (
    .a (cnt),
    .y (cnt_rev)
  );

  // Outputs decode from registered state only.
  assign phase     = ph;
  assign in_ready  = (ph == PH_LOAD);
  assign out_valid = (ph == PH_UNLOAD);
  assign bfly_en   = (ph == PH_COMPUTE);
  assign busy      = (ph != PH_IDLE);
  assign done      = (ph == PH_DONE);
  assign addr      = (ph == PH_UNLOAD) ? cnt_rev : cnt;

endmodule

// File: tb/tb_cf_fft_1024_8_seq.sv
// Directed bench for the FFT sequencer: a default-size instance and an 8-point
// instance share one clock.
module tb_cf_fft_1024_8_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, in_valid, out_ready;
  logic       in_ready, out_valid, bfly_en, busy, done;
  logic [2:0] phase;
  logic [9:0] addr;
  logic [8:0] bfly_idx;
  logic [3:0] stage;

  logic       s_rst, s_start, s_in_valid, s_out_ready;
  logic       s_in_ready, s_out_valid, s_bfly_en, s_busy, s_done;
  logic [2:0] s_phase;
  logic [2:0] s_addr;
  logic [1:0] s_bfly_idx;
  logic [3:0] s_stage;

  int checks;
  int failures;

  cf_fft_1024_8_seq u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .phase(phase), .addr(addr),
    .bfly_idx(bfly_idx), .stage(stage), .bfly_en(bfly_en), .busy(busy), .done(done)
  );

  cf_fft_1024_8_seq #(.LOG2N(3), .BFLY_LAT(3)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_ready(s_out_ready), .out_valid(s_out_valid), .phase(s_phase), .addr(s_addr),
    .bfly_idx(s_bfly_idx), .stage(s_stage), .bfly_en(s_bfly_en), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] x);
    return {x[0], x[1], x[2], x[3], x[4], x[5], x[6], x[7], x[8], x[9]};
  endfunction

  // Full 8-point run with handshakes always high; optionally keeps start asserted.
  task automatic run_small(input logic hold, input string tg);
    logic [2:0] rev8 [8];
    int errs;
    rev8 = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    s_in_valid  = 1'b1;
    s_out_ready = 1'b1;
    s_start     = 1'b1;
    tick;
    s_start = hold;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_phase !== 3'b001 || s_addr !== 3'(i) || s_in_ready !== 1'b1 || s_busy !== 1'b1) errs++;
      tick;
    end
    chk({tg, "_load_seq"}, errs, 0);
    errs = 0;
    for (int st = 0; st < 3; st++) begin
      for (int b = 0; b < 4; b++) begin
        if (s_phase !== 3'b011 || s_stage !== 4'(st) || s_bfly_idx !== 2'(b) || s_bfly_en !== 1'b1) errs++;
        tick;
      end
      for (int d = 0; d < 3; d++) begin
        if (s_phase !== 3'b010 || s_stage !== 4'(st) || s_bfly_en !== 1'b0) errs++;
        tick;
      end
    end
    chk({tg, "_compute_drain_seq"}, errs, 0);
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_phase !== 3'b110 || s_out_valid !== 1'b1 || s_addr !== rev8[i]) errs++;
      tick;
    end
    chk({tg, "_unload_bitrev_seq"}, errs, 0);
    chk({tg, "_done_phase"}, s_phase, 3'b100);
    chk({tg, "_done_pulse"}, s_done, 1'b1);
    tick;
    chk({tg, "_after_done_phase"}, s_phase, 3'b000);
    chk({tg, "_after_done_pulse"}, s_done, 1'b0);
    tick;
    chk({tg, "_next_phase"}, s_phase, hold ? 3'b001 : 3'b000);
    s_start = 1'b0;
    s_rst   = 1'b1;
    tick;
    s_rst = 1'b0;
  endtask

  initial begin
    int acc, k, cyc, errs, cnt, dones;
    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s_rst = 1'b1; s_start = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick;

    chk("rst_phase", phase, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_handshakes", {in_ready, out_valid, bfly_en, done}, 4'b0000);
    chk("rst_counters", {stage, bfly_idx, addr}, 23'd0);
    rst = 1'b0;
    s_rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (phase !== 3'b000 || busy !== 1'b0 || {in_ready, out_valid, bfly_en, done} !== 4'b0000) errs++;
    end
    chk("idle_20_cycles", errs, 0);

    run_small(1'b0, "small_pulse");
    run_small(1'b1, "small_held");

    // Default size: toggled in_valid, then stalled unload.
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t3_load_entry", phase, 3'b001);
    acc = 0; k = 0; errs = 0;
    while (phase == 3'b001 && k < 4000) begin
      in_valid = (k % 2 == 0);
      tick;
      if (in_valid) acc++;
      k++;
      if (phase == 3'b001 && addr !== 10'(acc)) errs++;
    end
    in_valid = 1'b0;
    chk("t3_load_addr_track", errs, 0);
    chk("t3_accepts", acc, 1024);
    chk("t3_load_cycles", k, 2047);
    chk("t3_compute_entry", {phase, stage, bfly_idx, bfly_en}, {3'b011, 4'd0, 9'd0, 1'b1});
    cyc = 0;
    while (phase != 3'b110 && cyc < 6000) begin
      tick;
      cyc++;
    end
    chk("t3_compute_cycles", cyc, 5150);

    out_ready = 1'b1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (addr !== rev10(10'(i)) || out_valid !== 1'b1) errs++;
      tick;
    end
    chk("t4_unload_first5", errs, 0);
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("t4_stall_addr", addr, 10'd640);
      chk("t4_stall_valid", out_valid, 1'b1);
      tick;
    end
    out_ready = 1'b1;
    tick;
    chk("t4_resume_addr", addr, 10'd384);
    cnt = 6; errs = 0;
    while (phase == 3'b110 && cnt < 2000) begin
      if (addr !== rev10(10'(cnt))) errs++;
      tick;
      cnt++;
    end
    chk("t4_unload_rest", errs, 0);
    chk("t4_unload_count", cnt, 1024);
    chk("t4_done", {phase, done}, {3'b100, 1'b1});
    tick;
    chk("t4_idle_after", {phase, busy}, {3'b000, 1'b0});

    // Abort in stage 2, then a clean full run.
    in_valid = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (!(phase == 3'b011 && stage == 4'd2) && cyc < 8000) begin
      tick;
      cyc++;
    end
    chk("t5_reached_stage2", {phase, stage}, {3'b011, 4'd2});
    rst = 1'b1;
    tick;
    chk("t5_abort_state", {phase, stage, bfly_en, busy}, {3'b000, 4'd0, 1'b0, 1'b0});
    rst = 1'b0;
    tick;
    chk("t5_stays_idle", {phase, out_valid}, {3'b000, 1'b0});
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1; dones = 0;
    while (phase != 3'b000 && cyc < 9000) begin
      if (done) dones++;
      tick;
      cyc++;
    end
    chk("t5_full_run_cycles", cyc, 7200);
    chk("t5_done_pulses", dones, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
